traffic_light_fsm: RTL and testbench

//  Main-street/side-street light sequencer. Drives the timer block (start_timer, timer_value)
//  and advances one phase per expired pulse. Samples the side-street car sensor to extend greens
//  and inserts a pedestrian walk phase on request. Sits between the sensor/button synchronisers
//  and the timer; its light outputs go straight to the lamp drivers.

---
 rtl/traffic_light_fsm_pkg.sv | 30 +++
 rtl/traffic_light_fsm_walk_request_latch.sv | 20 ++
 rtl/traffic_light_fsm.sv | 147 ++++++++++++++
 tb/tb_traffic_light_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_fsm_pkg.sv
// Shared encodings for the traffic light sequencer: phase states, interval select codes
// (also used by the timer block) and one-hot {R,Y,G} lamp patterns.
package traffic_light_fsm_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_MG1,
        ST_MG_EXT,
        ST_MG2,
        ST_MY,
        ST_WALK,
        ST_SG,
        ST_SG_EXT,
        ST_SY
    } state_t;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    // A zero load would make the timer wrap to 16 s, so zero becomes one second.
    function automatic logic [3:0] nonzero_interval(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_walk_request_latch.sv
// Sticky pedestrian-request flag: any set cycle raises it, clear (entry to WALK) wins over set.
module walk_request_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clear,
    output logic flag
);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag <= 1'b0;
        end else if (clear) begin
            flag <= 1'b0;
        end else if (set) begin
            flag <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side street light sequencer driving an external seconds timer.
// Build option: define TRAFFIC_WALK_EN to include the pedestrian walk phase.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter logic [3:0] T_BASE = 4'd6,
    parameter logic [3:0] T_EXT  = 4'd3,
    parameter logic [3:0] T_YEL  = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic [1:0] interval_sel,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk
);

    localparam logic [3:0] BASE_VAL = nonzero_interval(T_BASE);
    localparam logic [3:0] EXT_VAL  = nonzero_interval(T_EXT);
    localparam logic [3:0] YEL_VAL  = nonzero_interval(T_YEL);

    state_t     state;
    state_t     next_state;
    logic       walk_pending;
    logic       expired_ok;
    logic       entering;
    logic [1:0] sel_next;
    logic [3:0] value_next;
    logic [2:0] main_next;
    logic [2:0] side_next;
    logic       walk_next;

`ifdef TRAFFIC_WALK_EN
    logic walk_clear;

    assign walk_clear = entering && (next_state == ST_WALK);

    walk_request_latch u_walk_request_latch (
        .clk   (clk),
        .reset (reset),
        .set   (walk_request),
        .clear (walk_clear),
        .flag  (walk_pending)
    );
`else
    logic unused_walk_request;

    assign unused_walk_request = walk_request;
    assign walk_pending        = 1'b0;
`endif

    // A pulse that lands while the timer is being loaded is stale and must not skip a phase.
    assign expired_ok = expired && !start_timer && (state != ST_INIT);
    assign entering   = (next_state != state);

    always_comb begin
        next_state = state;
        if (state == ST_INIT) begin
            next_state = ST_MG1;
        end else if (expired_ok) begin
            case (state)
                ST_MG1:    next_state = sensor ? ST_MG_EXT : ST_MG2;
                ST_MG_EXT: next_state = ST_MY;
                ST_MG2:    next_state = ST_MY;
                ST_MY:     next_state = walk_pending ? ST_WALK : ST_SG;
                ST_WALK:   next_state = ST_SG;
                ST_SG:     next_state = sensor ? ST_SG_EXT : ST_SY;
                ST_SG_EXT: next_state = ST_SY;
                ST_SY:     next_state = ST_MG1;
                default:   next_state = ST_INIT;
            endcase
        end
    end

    always_comb begin
        sel_next  = SEL_BASE;
        main_next = LIGHT_RED;
        side_next = LIGHT_RED;
        walk_next = 1'b0;
        case (next_state)
            ST_MG1, ST_MG2: begin
                main_next = LIGHT_GRN;
            end
            ST_MG_EXT: begin
                main_next = LIGHT_GRN;
                sel_next  = SEL_EXT;
            end
            ST_MY: begin
                main_next = LIGHT_YEL;
                sel_next  = SEL_YEL;
            end
            ST_WALK: begin
                walk_next = 1'b1;
                sel_next  = SEL_EXT;
            end
            ST_SG: begin
                side_next = LIGHT_GRN;
            end
            ST_SG_EXT: begin
                side_next = LIGHT_GRN;
                sel_next  = SEL_EXT;
            end
            ST_SY: begin
                side_next = LIGHT_YEL;
                sel_next  = SEL_YEL;
            end
            default: begin
                sel_next = SEL_BASE;
            end
        endcase

        case (sel_next)
            SEL_EXT: value_next = EXT_VAL;
            SEL_YEL: value_next = YEL_VAL;
            default: value_next = BASE_VAL;
        endcase
    end

    // Lamps follow the next state so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            start_timer  <= 1'b0;
            timer_value  <= 4'd0;
            interval_sel <= SEL_BASE;
            main_lights  <= LIGHT_RED;
            side_lights  <= LIGHT_RED;
            walk         <= 1'b0;
        end else begin
            state       <= next_state;
            start_timer <= entering;
            main_lights <= main_next;
            side_lights <= side_next;
            walk        <= walk_next;
            if (entering) begin
                timer_value  <= value_next;
                interval_sel <= sel_next;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm with a 5-clock-per-second timer model.
// Expected phase entries are queued by the stimulus and checked by a monitor on start_timer.
module tb_traffic_light_fsm;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
        logic [3:0] value;
        logic [1:0] sel;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       timer_expired = 1'b0;
    logic       inject = 1'b0;
    logic       start_timer;
    logic [3:0] timer_value;
    logic [1:0] interval_sel;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;

    int     checks = 0;
    int     errors = 0;
    int     clocks_left = 0;
    entry_t expect_q[$];

    localparam entry_t E_MG1    = '{main: 3'b001, side: 3'b100, walk: 1'b0, value: 4'd6, sel: 2'b00};
    localparam entry_t E_MG_EXT = '{main: 3'b001, side: 3'b100, walk: 1'b0, value: 4'd3, sel: 2'b01};
    localparam entry_t E_MG2    = '{main: 3'b001, side: 3'b100, walk: 1'b0, value: 4'd6, sel: 2'b00};
    localparam entry_t E_MY     = '{main: 3'b010, side: 3'b100, walk: 1'b0, value: 4'd2, sel: 2'b10};
    localparam entry_t E_WALK   = '{main: 3'b100, side: 3'b100, walk: 1'b1, value: 4'd3, sel: 2'b01};
    localparam entry_t E_SG     = '{main: 3'b100, side: 3'b001, walk: 1'b0, value: 4'd6, sel: 2'b00};
    localparam entry_t E_SG_EXT = '{main: 3'b100, side: 3'b001, walk: 1'b0, value: 4'd3, sel: 2'b01};
    localparam entry_t E_SY     = '{main: 3'b100, side: 3'b010, walk: 1'b0, value: 4'd2, sel: 2'b10};

    traffic_light_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (timer_expired | inject),
        .start_timer  (start_timer),
        .timer_value  (timer_value),
        .interval_sel (interval_sel),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk         (walk)
    );

    always #5 clk = ~clk;

    // Seconds timer model: loads on start_timer, pulses expired after 5*value clocks.
    always @(posedge clk) begin
        timer_expired <= 1'b0;
        if (reset) begin
            clocks_left <= 0;
        end else if (start_timer) begin
            clocks_left <= 5 * int'(timer_value);
        end else if (clocks_left != 0) begin
            clocks_left <= clocks_left - 1;
            if (clocks_left == 1) begin
                timer_expired <= 1'b1;
            end
        end
    end

    // Monitor: every phase entry must match the oldest queued expectation.
    always @(negedge clk) begin
        entry_t seen;
        entry_t want;
        if (start_timer) begin
            seen = '{main: main_lights, side: side_lights, walk: walk, value: timer_value, sel: interval_sel};
            checks++;
            if (expect_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_entry actual main=%b side=%b walk=%b value=%0d sel=%b required none",
                         seen.main, seen.side, seen.walk, seen.value, seen.sel);
            end else begin
                want = expect_q.pop_front();
                if (seen !== want) begin
                    errors++;
                    $display("[TB] FAIL phase_entry actual main=%b side=%b walk=%b value=%0d sel=%b required main=%b side=%b walk=%b value=%0d sel=%b",
                             seen.main, seen.side, seen.walk, seen.value, seen.sel,
                             want.main, want.side, want.walk, want.value, want.sel);
                end
            end
        end
    end

    task automatic applyStimulus(input logic new_sensor, input logic new_walk_request);
        sensor       = new_sensor;
        walk_request = new_walk_request;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic pushEntry(input entry_t e);
        expect_q.push_back(e);
    endtask

    task automatic waitEmpty(input string name, input int limit);
        int cycles = 0;
        while (expect_q.size() != 0 && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (expect_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=%0d_pending required=0_pending", name, expect_q.size());
            expect_q.delete();
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_main"}, 16'(main_lights), 16'(3'b100));
        checkOutput({name, "_side"}, 16'(side_lights), 16'(3'b100));
        checkOutput({name, "_walk"}, 16'(walk), 16'd0);
        checkOutput({name, "_start"}, 16'(start_timer), 16'd0);
    endtask

    initial begin
        int cycles;

        // Reset and the plain cycle with no car and no pedestrian.
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        checkOutput("reset_value", 16'(timer_value), 16'd0);
        checkOutput("reset_sel", 16'(interval_sel), 16'd0);
        pushEntry(E_MG1);
        pushEntry(E_MG2);
        pushEntry(E_MY);
        pushEntry(E_SG);
        pushEntry(E_SY);
        pushEntry(E_MG1);
        reset = 1'b0;
        checkOutput("init_start", 16'(start_timer), 16'd0);
        @(posedge clk);
        #1;
        checkOutput("first_start", 16'(start_timer), 16'd1);
        checkOutput("first_value", 16'(timer_value), 16'd6);
        waitEmpty("plain_cycle", 1000);

        // Car waiting during MG1 expiry extends the main green.
        applyStimulus(1'b1, 1'b0);
        pushEntry(E_MG_EXT);
        pushEntry(E_MY);
        waitEmpty("main_extension", 500);
        applyStimulus(1'b0, 1'b0);

        // One-cycle walk request during SG, served after the next MY, then a lap without walk.
        pushEntry(E_SG);
        waitEmpty("enter_sg", 500);
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0);
        pushEntry(E_SY);
        pushEntry(E_MG1);
        pushEntry(E_MG2);
        pushEntry(E_MY);
`ifdef TRAFFIC_WALK_EN
        pushEntry(E_WALK);
`endif
        pushEntry(E_SG);
        pushEntry(E_SY);
        pushEntry(E_MG1);
        pushEntry(E_MG2);
        pushEntry(E_MY);
        pushEntry(E_SG);
        waitEmpty("walk_laps", 2500);

        // Reset mid SG_EXT with a walk pending: all red at once, restart without the walk.
        applyStimulus(1'b1, 1'b0);
        pushEntry(E_SG_EXT);
        waitEmpty("side_extension", 500);
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("midphase_reset");
        pushEntry(E_MG1);
        pushEntry(E_MG2);
        pushEntry(E_MY);
        reset = 1'b0;
        waitEmpty("after_reset", 1000);

        // Expired coincident with start_timer must not advance SG.
        pushEntry(E_SG);
        cycles = 0;
        while (!start_timer && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("sg_start_seen", 16'(start_timer), 16'd1);
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        checkOutput("stale_start", 16'(start_timer), 16'd0);
        checkOutput("stale_main", 16'(main_lights), 16'(3'b100));
        checkOutput("stale_side", 16'(side_lights), 16'(3'b001));
        pushEntry(E_SY);
        pushEntry(E_MG1);
        waitEmpty("after_stale", 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
